// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: drives a req/ack data-memory handshake with byte lanes,
// stalls the core while an access is in flight and returns extended load data.
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  mem_code,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [1:0]  fault,
    output logic [31:0] rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] F_OK    = 2'b00;
    localparam logic [1:0] F_ALIGN = 2'b01;
    localparam logic [1:0] F_BUS   = 2'b10;
    localparam logic [1:0] F_CODE  = 2'b11;

    state_e      state_q, state_d;
    logic [2:0]  code_q;
    logic        we_q;
    logic [1:0]  off_q;
    logic [7:0]  cnt_q;
    logic [1:0]  fault_q;
    logic [31:0] rdata_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wd_q;

    logic        launch;
    logic        illegal;
    logic        misal;
    logic        last;
    logic [3:0]  be_d;
    logic [31:0] wd_d;
    logic [31:0] ld_shift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Access decode, only meaningful while IDLE sees a new instruction
    always_comb begin
        launch  = start && (mem_code != 3'b000);
        illegal = (mem_code == 3'b100) || (mem_code == 3'b111)
                  || (mem_write && mem_code[2]);
        misal   = ((mem_code[1:0] == 2'b10) && addr[0])
                  || ((mem_code[1:0] == 2'b11) && (addr[1:0] != 2'b00));
        last    = (cnt_q == CNT_LAST);
    end

    always_comb begin
        be_d = 4'b1111;
        wd_d = wdata;
        case (mem_code[1:0])
            2'b01: begin
                be_d = 4'b0001 << addr[1:0];
                wd_d = {4{wdata[7:0]}};
            end
            2'b10: begin
                be_d = addr[1] ? 4'b1100 : 4'b0011;
                wd_d = {2{wdata[15:0]}};
            end
            default: begin
                be_d = 4'b1111;
                wd_d = wdata;
            end
        endcase
    end

    always_comb begin
        ld_shift = dmem_rdata >> {off_q, 3'b000};
        ld_byte  = ld_shift[7:0];
        ld_half  = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (code_q)
            3'b001:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b101:  ld_ext = {24'h0, ld_byte};
            3'b010:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b110:  ld_ext = {16'h0, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d = (illegal || misal) ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                if (dmem_ack) begin
                    state_d = S_DONE;
                end else if (last) begin
                    state_d = S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        done     = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        fault    = F_OK;
        case (state_q)
            S_IDLE: stall = launch;
            S_REQ: begin
                stall    = 1'b1;
                dmem_req = 1'b1;
                dmem_we  = we_q;
            end
            S_DONE: done = 1'b1;
            S_ERR: begin
                done  = 1'b1;
                fault = fault_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= 3'b000;
            we_q    <= 1'b0;
            off_q   <= 2'b00;
            cnt_q   <= 8'h00;
            fault_q <= F_OK;
            rdata_q <= 32'h0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wd_q    <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        if (illegal) begin
                            fault_q <= F_CODE;
                        end else if (misal) begin
                            fault_q <= F_ALIGN;
                        end else begin
                            fault_q <= F_OK;
                            code_q  <= mem_code;
                            we_q    <= mem_write;
                            off_q   <= addr[1:0];
                            cnt_q   <= 8'h00;
                            addr_q  <= {addr[31:2], 2'b00};
                            be_q    <= be_d;
                            wd_q    <= wd_d;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_ack) begin
                        fault_q <= F_OK;
                        if (!we_q) begin
                            rdata_q <= ld_ext;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'h01;
                        if (last) begin
                            fault_q <= F_BUS;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata      = rdata_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wd_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomised and directed bench for lsu_mem_ctrl against a
// transaction-level reference model of the access rules.
module tb_lsu_mem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  mem_code;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [1:0]  fault;
    logic [31:0] rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_rdata = 32'h0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mem_code   (mem_code),
        .mem_write  (mem_write),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .done       (done),
        .fault      (fault),
        .rdata      (rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    // One complete instruction: dly is the REQ cycle (0-based) in which
    // memory acks; dly >= TO means memory never answers.
    task automatic access(input logic [2:0] code, input logic we,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int dly,
                          input string nm);
        bit          illegal, misal, seen;
        int          sz, off, k, reqs, exp_k, exp_reqs;
        logic [1:0]  f;
        logic [3:0]  be;
        logic [31:0] w, ld;
        logic [7:0]  bv;
        logic [15:0] hv;
        sz  = int'(code[1:0]);
        off = int'(a[1:0]);
        illegal = (code == 3'd4) || (code == 3'd7)
                  || (we && (code == 3'd5 || code == 3'd6));
        misal = (sz == 2 && off % 2 != 0) || (sz == 3 && off != 0);
        if (sz == 1) begin
            be = 4'(1 << off);
            w  = {4{wd[7:0]}};
        end else if (sz == 2) begin
            be = (off >= 2) ? 4'b1100 : 4'b0011;
            w  = {2{wd[15:0]}};
        end else begin
            be = 4'b1111;
            w  = wd;
        end
        bv = rd[8*off +: 8];
        hv = rd[16*(off/2) +: 16];
        case (code)
            3'd1: ld = {{24{bv[7]}}, bv};
            3'd5: ld = {24'h0, bv};
            3'd2: ld = {{16{hv[15]}}, hv};
            3'd6: ld = {16'h0, hv};
            default: ld = rd;
        endcase
        if (illegal) f = 2'b11;
        else if (misal) f = 2'b01;
        else if (dly < TO) f = 2'b00;
        else f = 2'b10;
        if (f == 2'b11 || f == 2'b01) begin
            exp_k = 1; exp_reqs = 0;
        end else if (f == 2'b00) begin
            exp_k = dly + 2; exp_reqs = dly + 1;
        end else begin
            exp_k = TO + 1; exp_reqs = TO;
        end

        @(negedge clk);
        start = 1'b1; mem_code = code; mem_write = we;
        addr = a; wdata = wd; dmem_ack = 1'b0;
        #1;
        vectors++;
        if (stall !== (code != 3'd0) || done !== 1'b0 || dmem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL %s launch: stall=%b done=%b req=%b, want stall=%b done=0 req=0",
                     nm, stall, done, dmem_req, code != 3'd0);
        end
        if (code == 3'd0) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            vectors++;
            if (done !== 1'b0 || stall !== 1'b0 || dmem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL %s none-code: done=%b stall=%b req=%b, want 0 0 0",
                         nm, done, stall, dmem_req);
            end
            return;
        end

        k = 0; reqs = 0; seen = 0;
        while (k < TO + 10 && !seen) begin
            @(negedge clk);
            k++;
            start = 1'b0; mem_code = 3'($urandom); mem_write = 1'($urandom);
            addr = $urandom; wdata = $urandom;
            dmem_ack = 1'b0; dmem_rdata = $urandom;
            #1;
            if (done) begin
                seen = 1;
            end else if (dmem_req) begin
                reqs++;
                vectors++;
                if (dmem_addr !== {a[31:2], 2'b00} || dmem_be !== be
                    || dmem_we !== we || dmem_wdata !== w || stall !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s req: addr=%h be=%b we=%b wd=%h st=%b, want %h %b %b %h 1",
                             nm, dmem_addr, dmem_be, dmem_we, dmem_wdata, stall,
                             {a[31:2], 2'b00}, be, we, w);
                end
                if (reqs - 1 == dly) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rd;
                end
            end else begin
                vectors++;
                miscompares++;
                $display("FAIL %s gap: cycle %0d has neither req nor done", nm, k);
            end
        end
        dmem_ack = 1'b0;
        if (f == 2'b00 && !we) exp_rdata = ld;
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s no-done: waited %0d cycles, want done at %0d", nm, k, exp_k);
            return;
        end
        if (fault !== f || k != exp_k || reqs != exp_reqs || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done: fault=%b cyc=%0d reqs=%0d stall=%b, want %b %0d %0d 0",
                     nm, fault, k, reqs, stall, f, exp_k, exp_reqs);
        end
        vectors++;
        if (rdata !== exp_rdata) begin
            miscompares++;
            $display("FAIL %s rdata: got %h, want %h", nm, rdata, exp_rdata);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mem_code = 3'd0; mem_write = 1'b0;
        addr = 32'h0; wdata = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        #12;
        vectors++;
        if ({stall, done, dmem_req, dmem_we, fault, dmem_be} !== 10'h0
            || rdata !== 32'h0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: st=%b dn=%b rq=%b we=%b f=%b be=%b rd=%h a=%h wd=%h, want all 0",
                     stall, done, dmem_req, dmem_we, fault, dmem_be, rdata,
                     dmem_addr, dmem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store();
        access(3'd1, 1'b1, 32'h103, 32'h0000_00A5, 32'h0, 0, "sb");
        access(3'd2, 1'b1, 32'h202, 32'h1234_5678, 32'h0, 1, "sh");
        access(3'd3, 1'b1, 32'h300, 32'hDEAD_BEEF, 32'h0, 2, "sw");
    endtask

    task automatic test_load();
        access(3'd1, 1'b0, 32'h1, 32'h0, 32'h80FF_7F01, 0, "lb1");
        access(3'd1, 1'b0, 32'h2, 32'h0, 32'h80FF_7F01, 0, "lb2");
        access(3'd1, 1'b0, 32'h3, 32'h0, 32'h80FF_7F01, 0, "lb3");
        access(3'd5, 1'b0, 32'h3, 32'h0, 32'h80FF_7F01, 1, "lbu3");
        access(3'd2, 1'b0, 32'h2, 32'h0, 32'h9ABC_1234, 0, "lh2");
        access(3'd6, 1'b0, 32'h2, 32'h0, 32'h9ABC_1234, 0, "lhu2");
        access(3'd3, 1'b0, 32'h6, 32'h0, 32'h1111_2222, 0, "lw-mis");
        access(3'd2, 1'b1, 32'h7, 32'h5, 32'h0, 0, "sh-mis");
    endtask

    task automatic test_illegal();
        access(3'd4, 1'b0, 32'h0, 32'h0, 32'h0, 0, "code100");
        access(3'd7, 1'b0, 32'h0, 32'h0, 32'h0, 0, "code111");
        access(3'd5, 1'b1, 32'h0, 32'h0, 32'h0, 0, "sbu");
        access(3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 0, "none");
    endtask

    task automatic test_timeout();
        access(3'd3, 1'b0, 32'h40, 32'h0, 32'h0, 50, "timeout");
        access(3'd3, 1'b0, 32'h44, 32'h0, 32'hCAFE_F00D, TO - 1, "late-ack");
        access(3'd3, 1'b1, 32'h48, 32'h1, 32'h0, 50, "st-timeout");
    endtask

    task automatic test_back_to_back();
        access(3'd3, 1'b0, 32'h80, 32'h0, 32'h0BAD_CAFE, 0, "b2b-a");
        start = 1'b1; mem_code = 3'd3; mem_write = 1'b0; addr = 32'h0;
        @(negedge clk);
        start = 1'b0;
        #1;
        vectors++;
        if (dmem_req !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL done-ignores-start: req=%b done=%b stall=%b, want 0 0 0",
                     dmem_req, done, stall);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        vectors++;
        if (done !== 1'b0 || rdata !== exp_rdata) begin
            miscompares++;
            $display("FAIL idle-ack: done=%b rdata=%h, want 0 %h", done, rdata, exp_rdata);
        end
        access(3'd6, 1'b0, 32'h82, 32'h0, 32'h8001_7FFE, 0, "b2b-b");
        access(3'd1, 1'b1, 32'h81, 32'h0000_0077, 32'h0, 0, "b2b-c");
    endtask

    task automatic test_random();
        logic [2:0] codes [6];
        codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
        for (int i = 0; i < 60; i++) begin
            logic [2:0] c;
            c = (i % 10 == 9) ? 3'($urandom) : codes[$urandom_range(5, 0)];
            access(c, 1'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(TO + 1, 0)), "rand");
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; mem_code = 3'd3; mem_write = 1'b0; addr = 32'h40;
        @(negedge clk);
        start = 1'b0;
        #1;
        vectors++;
        if (dmem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL rst-pre: req=%b, want 1", dmem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_rdata = 32'h0;
        vectors++;
        if (dmem_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst-mid: req=%b stall=%b done=%b, want 0 0 0",
                     dmem_req, stall, done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        vectors++;
        if (done !== 1'b0 || rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rst-after: done=%b rdata=%h, want 0 0", done, rdata);
        end
        access(3'd3, 1'b0, 32'h0, 32'h0, $urandom, 0, "lw-after-rst");
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
